// File: rtl/trapezoid_raster_stream.sv
// Scan-converts one flat-top/flat-bottom trapezoid into a raster-ordered pixel stream.
// Optional per-row end-of-line flag is enabled by defining TRAP_ROW_EOL_EN.
module trapezoid_raster_stream #(
  parameter int W    = 8,
  parameter int FRAC = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         nt,
  input  logic [W-1:0] xi,
  input  logic [W-1:0] yi,
  output logic         busy,
  output logic         po,
  output logic [W-1:0] xo,
  output logic [W-1:0] yo,
  input  logic         ready,
  output logic         done
`ifdef TRAP_ROW_EOL_EN
  ,
  output logic         eol
`endif
);

  localparam int DIV_CYC = W + FRAC + 1;
  localparam int AW      = W + FRAC + 2;
  localparam int CW      = $clog2(DIV_CYC + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_DIV      = 3'd2;
  localparam logic [2:0] S_ROW_INIT = 3'd3;
  localparam logic [2:0] S_EMIT     = 3'd4;
  localparam logic [2:0] S_ROW_STEP = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [1:0]          ld_cnt_q, ld_cnt_d;
  logic [W-1:0]        xlt_q, xlt_d, yt_q, yt_d, xrt_q, xrt_d;
  logic [W-1:0]        xlb_q, xlb_d, xrb_q, xrb_d, yb_q, yb_d;
  logic [W-1:0]        x_q, x_d, xe_q, xe_d, y_q, y_d;
  logic [CW-1:0]       div_cnt_q, div_cnt_d;
  logic [W-1:0]        den_q, den_d;
  logic [W-1:0]        rem_l_q, rem_l_d, rem_r_q, rem_r_d;
  logic [DIV_CYC-1:0]  quo_l_q, quo_l_d, quo_r_q, quo_r_d;
  logic                neg_l_q, neg_l_d, neg_r_q, neg_r_d;
  logic signed [AW-1:0] xl_q, xl_d, xr_q, xr_d;

  // Divider datapath, edge slopes and row span, all from registered state.
  logic [W:0]           diff_l, diff_r, mag_l, mag_r;
  logic [W:0]           sh_l, sh_r;
  logic                 ge_l, ge_r;
  logic signed [AW-1:0] dxl, dxr, xs_full, xe_full;

  always_comb begin
    diff_l = {1'b0, xlb_q} - {1'b0, xlt_q};
    diff_r = {1'b0, xrb_q} - {1'b0, xrt_q};
    mag_l  = diff_l[W] ? (~diff_l + 1'b1) : diff_l;
    mag_r  = diff_r[W] ? (~diff_r + 1'b1) : diff_r;
    sh_l   = {rem_l_q, quo_l_q[DIV_CYC-1]};
    sh_r   = {rem_r_q, quo_r_q[DIV_CYC-1]};
    ge_l   = (sh_l >= {1'b0, den_q});
    ge_r   = (sh_r >= {1'b0, den_q});
    dxl    = $signed({1'b0, quo_l_q});
    dxr    = $signed({1'b0, quo_r_q});
    if (neg_l_q) dxl = -dxl;
    if (neg_r_q) dxr = -dxr;
    xs_full = (xl_q + $signed({{(AW-FRAC){1'b0}}, {FRAC{1'b1}}})) >>> FRAC;
    xe_full = xr_q >>> FRAC;
  end

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    xlt_d     = xlt_q;
    yt_d      = yt_q;
    xrt_d     = xrt_q;
    xlb_d     = xlb_q;
    xrb_d     = xrb_q;
    yb_d      = yb_q;
    x_d       = x_q;
    xe_d      = xe_q;
    y_d       = y_q;
    div_cnt_d = div_cnt_q;
    den_d     = den_q;
    rem_l_d   = rem_l_q;
    rem_r_d   = rem_r_q;
    quo_l_d   = quo_l_q;
    quo_r_d   = quo_r_q;
    neg_l_d   = neg_l_q;
    neg_r_d   = neg_r_q;
    xl_d      = xl_q;
    xr_d      = xr_q;
    case (state_q)
      S_IDLE: begin
        if (nt) begin
          xlt_d    = xi;
          yt_d     = yi;
          ld_cnt_d = 2'd0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_cnt_d = ld_cnt_q + 2'd1;
        case (ld_cnt_q)
          2'd0:    xrt_d = xi;
          2'd1:    xlb_d = xi;
          default: begin
            xrb_d     = xi;
            yb_d      = yi;
            y_d       = yt_q;
            xl_d      = $signed({2'b00, xlt_q, {FRAC{1'b0}}});
            xr_d      = $signed({2'b00, xrt_q, {FRAC{1'b0}}});
            div_cnt_d = '0;
            state_d   = (yi < yt_q) ? S_DONE : S_DIV;
          end
        endcase
      end
      S_DIV: begin
        // Count 0 is operand setup; counts 1..DIV_CYC are the restoring iterations.
        if (div_cnt_q == '0) begin
          if (yb_q == yt_q) begin
            state_d = S_ROW_INIT;
          end else begin
            den_d     = yb_q - yt_q;
            rem_l_d   = '0;
            rem_r_d   = '0;
            neg_l_d   = diff_l[W];
            neg_r_d   = diff_r[W];
            quo_l_d   = {1'b0, mag_l[W-1:0], {FRAC{1'b0}}};
            quo_r_d   = {1'b0, mag_r[W-1:0], {FRAC{1'b0}}};
            div_cnt_d = CW'(1);
          end
        end else begin
          rem_l_d = ge_l ? (sh_l[W-1:0] - den_q) : sh_l[W-1:0];
          rem_r_d = ge_r ? (sh_r[W-1:0] - den_q) : sh_r[W-1:0];
          quo_l_d = {quo_l_q[DIV_CYC-2:0], ge_l};
          quo_r_d = {quo_r_q[DIV_CYC-2:0], ge_r};
          if (div_cnt_q == CW'(DIV_CYC)) state_d = S_ROW_INIT;
          else div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      S_ROW_INIT: begin
        if (xs_full > xe_full) begin
          state_d = S_ROW_STEP;
        end else begin
          x_d     = xs_full[W-1:0];
          xe_d    = xe_full[W-1:0];
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (ready) begin
          if (x_q == xe_q) state_d = S_ROW_STEP;
          else x_d = x_q + W'(1);
        end
      end
      S_ROW_STEP: begin
        if (y_q == yb_q) begin
          state_d = S_DONE;
        end else begin
          y_d     = y_q + W'(1);
          state_d = S_ROW_INIT;
          // The bottom row snaps to the exact vertices so slope truncation never drifts.
          if (y_q + W'(1) == yb_q) begin
            xl_d = $signed({2'b00, xlb_q, {FRAC{1'b0}}});
            xr_d = $signed({2'b00, xrb_q, {FRAC{1'b0}}});
          end else begin
            xl_d = xl_q + dxl;
            xr_d = xr_q + dxr;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ld_cnt_q  <= '0;
      xlt_q     <= '0;
      yt_q      <= '0;
      xrt_q     <= '0;
      xlb_q     <= '0;
      xrb_q     <= '0;
      yb_q      <= '0;
      x_q       <= '0;
      xe_q      <= '0;
      y_q       <= '0;
      div_cnt_q <= '0;
      den_q     <= '0;
      rem_l_q   <= '0;
      rem_r_q   <= '0;
      quo_l_q   <= '0;
      quo_r_q   <= '0;
      neg_l_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      xl_q      <= '0;
      xr_q      <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      xlt_q     <= xlt_d;
      yt_q      <= yt_d;
      xrt_q     <= xrt_d;
      xlb_q     <= xlb_d;
      xrb_q     <= xrb_d;
      yb_q      <= yb_d;
      x_q       <= x_d;
      xe_q      <= xe_d;
      y_q       <= y_d;
      div_cnt_q <= div_cnt_d;
      den_q     <= den_d;
      rem_l_q   <= rem_l_d;
      rem_r_q   <= rem_r_d;
      quo_l_q   <= quo_l_d;
      quo_r_q   <= quo_r_d;
      neg_l_q   <= neg_l_d;
      neg_r_q   <= neg_r_d;
      xl_q      <= xl_d;
      xr_q      <= xr_d;
    end
  end

  // Handshake: a pixel transfers on a rising edge where po && ready; po, xo, yo hold until then.
  assign po   = (state_q == S_EMIT);
  assign busy = (state_q == S_DIV) || (state_q == S_ROW_INIT) ||
                (state_q == S_EMIT) || (state_q == S_ROW_STEP);
  assign done = (state_q == S_DONE);
  assign xo   = x_q;
  assign yo   = y_q;
`ifdef TRAP_ROW_EOL_EN
  assign eol  = po && (x_q == xe_q);
`endif

endmodule
